scr1_tb_log_sched: RTL and testbench

Testbench-side scheduler for instruction-event logging in the SCR1 AHB top testbench. Two requesters (e.g. the IFU→IDU instruction stream and a second probe point) present fetched instructions. The block filters for the XOR encoding, snapshots `mstatus`/`mcycle` at capture, and arbitrates round-robin into one record FIFO. It then drains records through a valid/ready port to the log printer.

---
 rtl/scr1_tb_log_sched.sv | 164 ++++++++++++++++
 tb/tb_scr1_tb_log_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_tb_log_sched.sv
// Instruction-event log scheduler: XOR filter, per-requester capture slot, round-robin into a record FIFO.
// Optional dropped-event counter enabled by `define SCR1_TB_LOG_DROP_CNT_EN (otherwise drop_cnt is 0).
module scr1_tb_log_sched #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [6:0] MATCH_OPCODE = 7'b0110011,
    parameter logic [2:0] MATCH_FUNCT3 = 3'b100
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req0_vld,
    input  logic [31:0]                     req0_pc,
    input  logic [31:0]                     req0_instr,
    input  logic                            req1_vld,
    input  logic [31:0]                     req1_pc,
    input  logic [31:0]                     req1_instr,
    input  logic [31:0]                     csr_mstatus,
    input  logic [63:0]                     csr_mcycle,
    output logic                            log_vld,
    input  logic                            log_rdy,
    output logic                            log_src,
    output logic [31:0]                     log_pc,
    output logic [31:0]                     log_instr,
    output logic [31:0]                     log_mstatus,
    output logic [63:0]                     log_mcycle,
    output logic [15:0]                     log_seq,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic [15:0]                     drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef struct packed {
        logic        src;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] mstatus;
        logic [63:0] mcycle;
        logic [15:0] seq;
    } rec_t;

    logic [1:0]  slot_vld_q, slot_vld_d;
    logic [31:0] slot_pc_q [2];
    logic [31:0] slot_pc_d [2];
    logic [31:0] slot_instr_q [2];
    logic [31:0] slot_instr_d [2];
    logic [31:0] slot_mst_q [2];
    logic [31:0] slot_mst_d [2];
    logic [63:0] slot_mcyc_q [2];
    logic [63:0] slot_mcyc_d [2];
    logic        rr_q, rr_d;
    logic [15:0] seq_q, seq_d;
    logic [LW-1:0] level_q, level_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    rec_t        mem_q [FIFO_DEPTH];

    logic [1:0]  match, moved, cap;
    logic        pop, push, can_push, grant_sel;
    rec_t        wr_rec, head;

    assign match[0] = req0_vld & (req0_instr[6:0] == MATCH_OPCODE) & (req0_instr[14:12] == MATCH_FUNCT3);
    assign match[1] = req1_vld & (req1_instr[6:0] == MATCH_OPCODE) & (req1_instr[14:12] == MATCH_FUNCT3);

    always_comb begin
        pop       = (level_q != '0) & log_rdy;
        can_push  = (level_q != LW'(FIFO_DEPTH)) | pop;
        grant_sel = (slot_vld_q == 2'b11) ? rr_q : slot_vld_q[1];
        push      = can_push & (slot_vld_q != 2'b00);
        moved     = push ? (grant_sel ? 2'b10 : 2'b01) : 2'b00;
        // a slot emptied by this cycle's grant can take a new event in the same cycle
        cap       = match & (~slot_vld_q | moved);
        slot_vld_d = (slot_vld_q & ~moved) | cap;

        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        slot_mst_d   = slot_mst_q;
        slot_mcyc_d  = slot_mcyc_q;
        if (cap[0]) begin
            slot_pc_d[0]    = req0_pc;
            slot_instr_d[0] = req0_instr;
            slot_mst_d[0]   = csr_mstatus;
            slot_mcyc_d[0]  = csr_mcycle;
        end
        if (cap[1]) begin
            slot_pc_d[1]    = req1_pc;
            slot_instr_d[1] = req1_instr;
            slot_mst_d[1]   = csr_mstatus;
            slot_mcyc_d[1]  = csr_mcycle;
        end

        wr_rec = '{src: grant_sel, pc: slot_pc_q[grant_sel], instr: slot_instr_q[grant_sel],
                   mstatus: slot_mst_q[grant_sel], mcycle: slot_mcyc_q[grant_sel], seq: seq_q};

        rr_d     = push ? ~grant_sel : rr_q;
        seq_d    = push ? seq_q + 16'd1 : seq_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld_q <= '0;
            for (int i = 0; i < 2; i++) begin
                slot_pc_q[i]    <= '0;
                slot_instr_q[i] <= '0;
                slot_mst_q[i]   <= '0;
                slot_mcyc_q[i]  <= '0;
            end
            rr_q     <= 1'b0;
            seq_q    <= '0;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            slot_vld_q   <= slot_vld_d;
            slot_pc_q    <= slot_pc_d;
            slot_instr_q <= slot_instr_d;
            slot_mst_q   <= slot_mst_d;
            slot_mcyc_q  <= slot_mcyc_d;
            rr_q         <= rr_d;
            seq_q        <= seq_d;
            level_q      <= level_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // storage is not reset; outputs are masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_rec;
    end

    assign log_vld     = (level_q != '0);
    assign head        = log_vld ? mem_q[rd_ptr_q] : '0;
    assign log_src     = head.src;
    assign log_pc      = head.pc;
    assign log_instr   = head.instr;
    assign log_mstatus = head.mstatus;
    assign log_mcycle  = head.mcycle;
    assign log_seq     = head.seq;
    assign fifo_level  = level_q;

`ifdef SCR1_TB_LOG_DROP_CNT_EN
    logic [1:0]  drop;
    logic [16:0] drop_sum;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop       = match & ~cap;
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop[0]) + 17'(drop[1]);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt_q <= '0;
        else     drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_scr1_tb_log_sched.sv
// Directed bench for scr1_tb_log_sched: filter vector table plus arbitration, backpressure, seq-wrap and reset sequences.
module tb_scr1_tb_log_sched;
`ifdef SCR1_TB_LOG_DROP_CNT_EN
    localparam logic [15:0] DROP_EXP = 16'd1;
`else
    localparam logic [15:0] DROP_EXP = 16'd0;
`endif
    localparam logic [31:0] XOR_I = 32'h00C5C533;
    localparam logic [31:0] ADD_I = 32'h00C585B3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req1_vld;
    logic [31:0] req0_pc, req1_pc, req0_instr, req1_instr;
    logic [31:0] csr_mstatus;
    logic [63:0] csr_mcycle;
    logic        log_vld, log_rdy, log_src;
    logic [31:0] log_pc, log_instr, log_mstatus;
    logic [63:0] log_mcycle;
    logic [15:0] log_seq;
    logic [2:0]  fifo_level;
    logic [15:0] drop_cnt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    scr1_tb_log_sched #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0_vld(req0_vld), .req0_pc(req0_pc), .req0_instr(req0_instr),
        .req1_vld(req1_vld), .req1_pc(req1_pc), .req1_instr(req1_instr),
        .csr_mstatus(csr_mstatus), .csr_mcycle(csr_mcycle),
        .log_vld(log_vld), .log_rdy(log_rdy), .log_src(log_src),
        .log_pc(log_pc), .log_instr(log_instr), .log_mstatus(log_mstatus),
        .log_mcycle(log_mcycle), .log_seq(log_seq),
        .fifo_level(fifo_level), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] mst;
        logic [63:0] mcyc;
        logic        exp_vld;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        req0_vld = 0; req1_vld = 0;
        req0_pc = 0; req1_pc = 0; req0_instr = 0; req1_instr = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int seq_err;
        vecs[0] = '{XOR_I,        32'h200,       32'h1800,      64'd100,                1'b1};
        vecs[1] = '{ADD_I,        32'h204,       32'h1800,      64'd101,                1'b0};
        vecs[2] = '{32'h00C5E533, 32'h208,       32'h1800,      64'd102,                1'b0};
        vecs[3] = '{32'h00C5C513, 32'h20C,       32'h1800,      64'd103,                1'b0};
        vecs[4] = '{32'h40C5C533, 32'h1234,      32'h88,        64'h1_0000_0005,        1'b1};
        vecs[5] = '{32'h0000C033, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

        log_rdy = 1'b1; csr_mstatus = 0; csr_mcycle = 0;
        do_reset();
        check("reset log_vld", log_vld, 0);
        check("reset fifo_level", fifo_level, 0);
        check("reset log_seq", log_seq, 0);
        check("reset log_pc", log_pc, 0);
        check("reset drop_cnt", drop_cnt, 0);

        // single-strobe filter and capture vectors
        for (int i = 0; i < 6; i++) begin
            do_reset();
            log_rdy = 1'b1;
            req0_vld = 1; req0_instr = vecs[i].instr; req0_pc = vecs[i].pc;
            csr_mstatus = vecs[i].mst; csr_mcycle = vecs[i].mcyc;
            @(negedge clk);
            check($sformatf("v%0d vld N+1", i), log_vld, 0);
            idle_inputs();
            csr_mstatus = ~vecs[i].mst; csr_mcycle = vecs[i].mcyc + 64'd7;
            @(negedge clk);
            check($sformatf("v%0d vld N+2", i), log_vld, vecs[i].exp_vld);
            if (vecs[i].exp_vld) begin
                check($sformatf("v%0d src", i), log_src, 0);
                check($sformatf("v%0d pc", i), log_pc, vecs[i].pc);
                check($sformatf("v%0d instr", i), log_instr, vecs[i].instr);
                check($sformatf("v%0d mstatus", i), log_mstatus, vecs[i].mst);
                check($sformatf("v%0d mcycle", i), log_mcycle, vecs[i].mcyc);
                check($sformatf("v%0d seq", i), log_seq, 0);
            end
            @(negedge clk);
            check($sformatf("v%0d vld after", i), log_vld, 0);
            check($sformatf("v%0d drop_cnt", i), drop_cnt, 0);
        end

        // ADD on both requesters for several cycles
        do_reset();
        req0_vld = 1; req1_vld = 1; req0_instr = ADD_I; req1_instr = ADD_I;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) idle_inputs();
            @(negedge clk);
            check("add no vld", log_vld, 0);
        end
        check("add level", fifo_level, 0);
        check("add drop_cnt", drop_cnt, 0);

        // simultaneous requesters, round-robin twice
        do_reset();
        log_rdy = 1'b1;
        for (int r = 0; r < 2; r++) begin
            req0_vld = 1; req0_instr = XOR_I; req0_pc = 32'h10;
            req1_vld = 1; req1_instr = XOR_I; req1_pc = 32'h20;
            @(negedge clk);
            idle_inputs();
            @(negedge clk);
            check("rr first vld", log_vld, 1);
            check("rr first src", log_src, 0);
            check("rr first pc", log_pc, 32'h10);
            check("rr first seq", log_seq, 16'(2 * r));
            @(negedge clk);
            check("rr second vld", log_vld, 1);
            check("rr second src", log_src, 1);
            check("rr second pc", log_pc, 32'h20);
            check("rr second seq", log_seq, 16'(2 * r + 1));
            @(negedge clk);
            check("rr drained", log_vld, 0);
        end

        // backpressure: 6 strobes into a 4-deep FIFO with the printer stalled
        do_reset();
        log_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            req0_vld = 1; req0_instr = XOR_I; req0_pc = 32'h300 + 32'(i);
            @(negedge clk);
        end
        idle_inputs();
        check("bp level full", fifo_level, 4);
        check("bp drop_cnt", drop_cnt, DROP_EXP);
        check("bp head pc", log_pc, 32'h300);
        @(negedge clk);
        check("bp head stable", log_pc, 32'h300);
        check("bp level stable", fifo_level, 4);
        log_rdy = 1'b1;
        n = 0;
        for (int k = 0; k < 20 && n < 5; k++) begin
            if (log_vld) begin
                check("bp drain seq", log_seq, 16'(n));
                check("bp drain pc", log_pc, 32'h300 + 32'(n));
                n++;
            end
            @(negedge clk);
        end
        check("bp drain count", n, 5);
        check("bp empty after", log_vld, 0);

        // reset asserted mid-drain
        do_reset();
        log_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req0_vld = 1; req0_instr = XOR_I; req0_pc = 32'h400 + 32'(i);
            @(negedge clk);
        end
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check("mid level 3", fifo_level, 3);
        log_rdy = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid rst vld", log_vld, 0);
        check("mid rst level", fifo_level, 0);
        check("mid rst seq", log_seq, 0);
        @(negedge clk);
        rst = 1'b0;
        req0_vld = 1; req0_instr = XOR_I; req0_pc = 32'h444;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("post rst vld", log_vld, 1);
        check("post rst pc", log_pc, 32'h444);
        check("post rst seq", log_seq, 0);

        // sustained stream of 65537 records to cross the seq wrap
        do_reset();
        log_rdy = 1'b1;
        n = 0; seq_err = 0;
        for (int c = 0; c < 65537 + 20 && n < 65537; c++) begin
            if (log_vld) begin
                if (log_seq !== 16'(n)) seq_err++;
                if (n == 65535) check("wrap seq ffff", log_seq, 16'hFFFF);
                if (n == 65536) begin
                    check("wrap seq 0000", log_seq, 16'h0000);
                    check("wrap pc", log_pc, 32'd65536);
                end
                n++;
            end
            req0_vld = (c < 65537); req0_instr = XOR_I; req0_pc = 32'(c);
            @(negedge clk);
        end
        idle_inputs();
        check("wrap count", n, 65537);
        check("wrap seq order errors", seq_err, 0);
        check("wrap drop_cnt", drop_cnt, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
